// File: rtl/axi_address_decoder_aw_router.sv
// AW-channel router for one target port: decodes AWADDR to a one-hot initiator,
// feeds the W decoder's destination FIFO, and sinks unmapped bursts with a DECERR B.
module axi_address_decoder_aw_router #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int N_INIT_PORT = 4,
  parameter int N_REGION    = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     awvalid_i,
  input  logic [ADDR_WIDTH-1:0]                    awaddr_i,
  input  logic [ID_WIDTH-1:0]                      awid_i,
  output logic                                     awready_o,
  output logic [N_INIT_PORT-1:0]                   awvalid_o,
  input  logic [N_INIT_PORT-1:0]                   awready_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]          enable_region_i,
  input  logic [N_INIT_PORT-1:0]                   connectivity_map_i,
  output logic [N_INIT_PORT-1:0]                   DEST_o,
  output logic                                     push_DEST_o,
  input  logic                                     grant_FIFO_DEST_i,
  input  logic                                     w_burst_done_i,
  output logic                                     handle_error_o,
  input  logic                                     wdata_error_completed_i,
  output logic                                     bvalid_err_o,
  input  logic                                     bready_err_i,
  output logic [ID_WIDTH-1:0]                      bid_err_o,
  output logic [1:0]                               bresp_err_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ERR_DRAIN, ERR_WDATA, ERR_BRESP} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]    bid_q;
  logic                   handle_q, bvalid_q;
  logic [N_INIT_PORT-1:0] hit, dest;
  logic                   miss, found, idle, accept_miss, done_eff;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      for (int r = 0; r < N_REGION; r++) begin
        if (enable_region_i[r*N_INIT_PORT+i] &&
            awaddr_i >= START_ADDR_i[(r*N_INIT_PORT+i)*ADDR_WIDTH +: ADDR_WIDTH] &&
            awaddr_i <= END_ADDR_i[(r*N_INIT_PORT+i)*ADDR_WIDTH +: ADDR_WIDTH]) begin
          hit[i] = hit[i] | connectivity_map_i[i];
        end
      end
    end
  end

  // Overlapping regions resolve to the lowest initiator index.
  always_comb begin
    dest  = '0;
    found = 1'b0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      if (hit[i] && !found) begin
        dest[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  // Handshake: a beat transfers on a cycle where valid and ready are both high;
  // valid never waits on ready, and ready may be offered without valid.
  assign miss        = (hit == '0);
  assign idle        = (state_q == IDLE);
  assign accept_miss = idle && awvalid_i && miss;
  assign DEST_o      = dest;
  assign awvalid_o   = (idle && awvalid_i && grant_FIFO_DEST_i) ? dest : '0;
  assign awready_o   = idle && (miss ? awvalid_i : ((|(awready_i & dest)) && grant_FIFO_DEST_i));
  assign push_DEST_o = idle && awvalid_i && !miss && awready_o;
  assign done_eff    = w_burst_done_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push_DEST_o && !done_eff) cnt_d = cnt_q + CNT_W'(1);
    else if (done_eff && !push_DEST_o) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bid_q    <= '0;
      handle_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (accept_miss) begin
            bid_q <= awid_i;
            if (cnt_d != '0) begin
              state_q <= ERR_DRAIN;
            end else begin
              state_q  <= ERR_WDATA;
              handle_q <= 1'b1;
            end
          end
        end
        ERR_DRAIN: begin
          if (cnt_d == '0) begin
            state_q  <= ERR_WDATA;
            handle_q <= 1'b1;
          end
        end
        ERR_WDATA: begin
          if (wdata_error_completed_i) begin
            state_q  <= ERR_BRESP;
            handle_q <= 1'b0;
            bvalid_q <= 1'b1;
          end
        end
        ERR_BRESP: begin
          if (bready_err_i) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign handle_error_o = handle_q;
  assign bvalid_err_o   = bvalid_q;
  assign bid_err_o      = bid_q;
  assign bresp_err_o    = 2'b11;

endmodule

// File: tb/tb_axi_address_decoder_aw_router.sv
// Bench for the AW router: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a region-table / flag-based model.
module tb_axi_address_decoder_aw_router;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int NI = 4;
  localparam int NR = 2;
  localparam int FD = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              awvalid;
  logic [AW-1:0]     awaddr;
  logic [IW-1:0]     awid;
  logic              awready_o;
  logic [NI-1:0]     awvalid_o;
  logic [NI-1:0]     awready_in;
  logic [NR*NI*AW-1:0] start_bus, end_bus;
  logic [NR*NI-1:0]  en_bus;
  logic [NI-1:0]     conn;
  logic [NI-1:0]     dest_o;
  logic              push_o;
  logic              grant;
  logic              w_done;
  logic              handle_o;
  logic              wcomp;
  logic              bvalid_o;
  logic              bready;
  logic [IW-1:0]     bid_o;
  logic [1:0]        bresp_o;

  axi_address_decoder_aw_router #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .N_INIT_PORT(NI), .N_REGION(NR), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid_i(awvalid), .awaddr_i(awaddr), .awid_i(awid), .awready_o(awready_o),
    .awvalid_o(awvalid_o), .awready_i(awready_in),
    .START_ADDR_i(start_bus), .END_ADDR_i(end_bus), .enable_region_i(en_bus),
    .connectivity_map_i(conn), .DEST_o(dest_o), .push_DEST_o(push_o),
    .grant_FIFO_DEST_i(grant), .w_burst_done_i(w_done), .handle_error_o(handle_o),
    .wdata_error_completed_i(wcomp), .bvalid_err_o(bvalid_o), .bready_err_i(bready),
    .bid_err_o(bid_o), .bresp_err_o(bresp_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  logic [AW-1:0] s_tab [NR][NI];
  logic [AW-1:0] e_tab [NR][NI];
  bit            en_tab[NR][NI];

  // Model: outstanding bursts plus flags describing where an error burst stands.
  int        m_out = 0;
  bit        m_err = 0, m_discard = 0, m_resp = 0;
  logic [IW-1:0] m_bid = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_region(input int r, input int i, input logic [AW-1:0] s,
                            input logic [AW-1:0] e, input bit en);
    s_tab[r][i] = s; e_tab[r][i] = e; en_tab[r][i] = en;
  endtask

  task automatic apply_map();
    for (int r = 0; r < NR; r++)
      for (int i = 0; i < NI; i++) begin
        start_bus[(r*NI+i)*AW +: AW] = s_tab[r][i];
        end_bus[(r*NI+i)*AW +: AW]   = e_tab[r][i];
        en_bus[r*NI+i]               = en_tab[r][i];
      end
  endtask

  function automatic logic [NI-1:0] ref_dest(input logic [AW-1:0] a, input logic [NI-1:0] c);
    logic [NI-1:0] one;
    for (int i = 0; i < NI; i++) begin
      if (c[i]) begin
        for (int r = 0; r < NR; r++) begin
          if (en_tab[r][i] && a >= s_tab[r][i] && a <= e_tab[r][i]) begin
            one = '0;
            one[i] = 1'b1;
            return one;
          end
        end
      end
    end
    return '0;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int r = $urandom_range(0, NR-1);
    int i = $urandom_range(0, NI-1);
    case ($urandom_range(0, 5))
      0: return s_tab[r][i];
      1: return e_tab[r][i];
      2: return s_tab[r][i] - 32'd1;
      3: return e_tab[r][i] + 32'd1;
      4: return 32'($urandom_range(0, 32'hFFFF));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_cycle();
    logic [NI-1:0] d, ev;
    bit idle, er, ep;
    int nxt;
    d    = ref_dest(awaddr, conn);
    idle = !m_err;
    ev   = (idle && awvalid && grant) ? d : '0;
    if (!idle) er = 1'b0;
    else if (d == '0) er = awvalid;
    else er = ((awready_in & d) != '0) && grant;
    ep = idle && awvalid && (d != '0) && er;
    if (check_en) begin
      chk("dest", 32'(dest_o), 32'(d));
      chk("awvalid_o", 32'(awvalid_o), 32'(ev));
      chk("awready_o", 32'(awready_o), 32'(er));
      chk("push", 32'(push_o), 32'(ep));
      chk("handle_error", 32'(handle_o), 32'(m_discard));
      chk("bvalid_err", 32'(bvalid_o), 32'(m_resp));
      chk("bid_err", 32'(bid_o), 32'(m_bid));
      chk("bresp_err", 32'(bresp_o), 32'h3);
    end
    if (!rst_n) begin
      m_out = 0; m_err = 0; m_discard = 0; m_resp = 0; m_bid = '0;
    end else begin
      nxt = m_out + (ep ? 1 : 0) - ((w_done && m_out > 0) ? 1 : 0);
      if (!m_err) begin
        if (idle && awvalid && d == '0) begin
          m_err = 1; m_bid = awid;
          if (nxt == 0) m_discard = 1;
        end
      end else if (m_resp) begin
        if (bready) begin m_err = 0; m_resp = 0; end
      end else if (m_discard) begin
        if (wcomp) begin m_discard = 0; m_resp = 1; end
      end else if (nxt == 0) begin
        m_discard = 1;
      end
      m_out = nxt;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    awvalid = 1'b0;
    for (int g = 0; g < 20 && m_out > 0; g++) begin
      w_done = 1'b1; tick();
    end
    w_done = 1'b0;
    chk("drain_done", 32'(m_out), 32'd0);
    tick();
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [NI-1:0] rdy);
    awvalid = 1'b1; awaddr = a; awid = id; awready_in = rdy;
    tick();
    awvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; awvalid = 1'b0; w_done = 1'b0; wcomp = 1'b0; bready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int bv_cnt;
  bit ar_low;

  initial begin
    rst_n = 1'b0; awvalid = 1'b0; awaddr = '0; awid = '0; awready_in = '0;
    conn = 4'hF; grant = 1'b1; w_done = 1'b0; wcomp = 1'b0; bready = 1'b0;
    set_region(0, 0, 32'h0000_0000, 32'h0000_0FFF, 1);
    set_region(1, 0, 32'hF000_0000, 32'hFFFF_FFFF, 1);
    set_region(0, 1, 32'h0000_3000, 32'h0000_3FFF, 1);
    set_region(1, 1, 32'h0000_8000, 32'h0000_8FFF, 1);
    set_region(0, 2, 32'h0000_1000, 32'h0000_1FFF, 1);
    set_region(1, 2, 32'h0000_5000, 32'h0000_5FFF, 0);
    set_region(0, 3, 32'h0000_3800, 32'h0000_4FFF, 1);
    set_region(1, 3, 32'h0000_9000, 32'h0000_9FFF, 0);
    apply_map();
    @(posedge clk); #1;
    tick(); tick();
    check_en = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_handle", 32'(handle_o), 32'h0);
    chk("rst_bvalid", 32'(bvalid_o), 32'h0);
    chk("rst_bid", 32'(bid_o), 32'h0);
    chk("rst_awvalid_o", 32'(awvalid_o), 32'h0);
    tick();

    // Basic hit on initiator 2
    awvalid = 1'b1; awaddr = 32'h1800; awid = 4'h5; awready_in = 4'b0100;
    #1;
    chk("t1_awvalid_o", 32'(awvalid_o), 32'h4);
    chk("t1_dest", 32'(dest_o), 32'h4);
    chk("t1_push", 32'(push_o), 32'h1);
    tick();
    awvalid = 1'b0; #1;
    chk("t1_push_once", 32'(push_o), 32'h0);
    tick();

    // Overlap resolves to lowest index, connectivity masks initiator 1
    awvalid = 1'b1; awaddr = 32'h3900; awready_in = 4'b0000; #1;
    chk("t2_overlap", 32'(awvalid_o), 32'h2);
    tick();
    conn = 4'b1101; #1;
    chk("t2_conn", 32'(awvalid_o), 32'h8);
    tick();
    conn = 4'hF; awvalid = 1'b0;

    // FIFO full blocks acceptance
    awvalid = 1'b1; awaddr = 32'h1800; awready_in = 4'hF; grant = 1'b0; #1;
    chk("t3_ready_full", 32'(awready_o), 32'h0);
    chk("t3_valid_full", 32'(awvalid_o), 32'h0);
    chk("t3_push_full", 32'(push_o), 32'h0);
    tick();
    grant = 1'b1; #1;
    chk("t3_ready_grant", 32'(awready_o), 32'h1);
    chk("t3_push_grant", 32'(push_o), 32'h1);
    tick();
    drain_all();

    // Miss behind two outstanding bursts
    send(32'h0100, 4'h1, 4'hF);
    send(32'h0200, 4'h2, 4'hF);
    awvalid = 1'b1; awaddr = 32'h2000; awid = 4'h9; #1;
    chk("t4_miss_ready", 32'(awready_o), 32'h1);
    chk("t4_miss_valid", 32'(awvalid_o), 32'h0);
    chk("t4_miss_push", 32'(push_o), 32'h0);
    tick();
    awaddr = 32'h0300; #1;
    chk("t4_drain_ready", 32'(awready_o), 32'h0);
    chk("t4_drain_handle", 32'(handle_o), 32'h0);
    tick();
    awvalid = 1'b0; w_done = 1'b1; tick();
    w_done = 1'b0; #1;
    chk("t4_one_done", 32'(handle_o), 32'h0);
    tick();
    w_done = 1'b1; tick();
    w_done = 1'b0; #1;
    chk("t4_handle", 32'(handle_o), 32'h1);
    tick();
    wcomp = 1'b1; tick();
    wcomp = 1'b0; #1;
    chk("t4_handle_drop", 32'(handle_o), 32'h0);
    chk("t4_bvalid", 32'(bvalid_o), 32'h1);
    chk("t4_bid", 32'(bid_o), 32'h9);
    chk("t4_bresp", 32'(bresp_o), 32'h3);
    bready = 1'b1; tick();
    bready = 1'b0; #1;
    chk("t4_bvalid_clr", 32'(bvalid_o), 32'h0);

    // Miss with nothing outstanding, B held while bready is low
    send(32'h6000, 4'hC, 4'hF);
    #1;
    chk("t5_handle", 32'(handle_o), 32'h1);
    wcomp = 1'b1; tick();
    wcomp = 1'b0;
    bv_cnt = 0; ar_low = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bready = (k == 3); awvalid = 1'b1; awaddr = 32'h1800; #1;
      if (bvalid_o === 1'b1) bv_cnt++;
      if (awready_o !== 1'b0) ar_low = 1'b0;
      tick();
    end
    bready = 1'b0; #1;
    chk("t5_bvalid_cycles", 32'(bv_cnt), 32'd4);
    chk("t5_awready_low", 32'(ar_low), 32'h1);
    chk("t5_accept_after", 32'(awready_o), 32'h1);
    tick();
    awvalid = 1'b0;
    drain_all();

    // Reset abandons an error burst; counter clears
    send(32'h0100, 4'h1, 4'hF);
    awvalid = 1'b1; awaddr = 32'h2000; awid = 4'h3; w_done = 1'b1; tick();
    awvalid = 1'b0; w_done = 1'b0; #1;
    chk("t6_wdata_direct", 32'(handle_o), 32'h1);
    do_reset(); #1;
    chk("t6_rst_handle", 32'(handle_o), 32'h0);
    chk("t6_rst_bvalid", 32'(bvalid_o), 32'h0);
    chk("t6_rst_bid", 32'(bid_o), 32'h0);
    send(32'h0100, 4'h1, 4'hF);
    send(32'h0200, 4'h2, 4'hF);
    do_reset();
    send(32'h2000, 4'h7, 4'hF);
    #1;
    chk("t6_cnt_cleared", 32'(handle_o), 32'h1);
    do_reset();
    awvalid = 1'b1; awaddr = 32'h0800; awready_in = 4'b0001; #1;
    chk("t6_route_valid", 32'(awvalid_o), 32'h1);
    chk("t6_route_push", 32'(push_o), 32'h1);
    tick();
    awvalid = 1'b0;
    drain_all();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) conn = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      awvalid    = ($urandom_range(0, 1) != 0);
      awaddr     = rand_addr();
      awid       = 4'($urandom_range(0, 15));
      awready_in = 4'($urandom_range(0, 15));
      grant      = (m_out >= FD) ? 1'b0 : ($urandom_range(0, 3) != 0);
      w_done     = (m_out > 0) ? ($urandom_range(0, 2) == 0)
                               : (!awvalid && $urandom_range(0, 3) == 0);
      wcomp      = m_discard ? ($urandom_range(0, 2) == 0) : 1'b0;
      bready     = ($urandom_range(0, 1) != 0);
      tick();
    end
    do_reset();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
